rr_req_arbiter8: RTL and testbench



---
 rtl/arb_pkg.sv | 34 +++
 rtl/arb_prio_enc8.sv | 62 ++++++
 rtl/rr_req_arbiter8.sv | 192 +++++++++++++++++++
 tb/tb_rr_req_arbiter8.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// arb_pkg
// Shared definitions for the 8-requester arbiter slice:
//   N_REQ / ID_W   requester count and grant index width (fixed at 8 / 3)
//   arb_state_t    arbiter FSM encoding {IDLE, GRANT}
//   rotate_right   rotation used to start the round-robin search after rr_ptr
//   onehot8        binary index to one-hot grant vector
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int ID_W  = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Result bit i is vec[(i + sh) mod N_REQ], so bit 0 is the first candidate.
  function automatic logic [N_REQ-1:0] rotate_right(
    input logic [N_REQ-1:0] vec,
    input logic [ID_W-1:0]  sh
  );
    logic [2*N_REQ-1:0] dbl;
    dbl = {vec, vec} >> sh;
    return dbl[N_REQ-1:0];
  endfunction

  function automatic logic [N_REQ-1:0] onehot8(input logic [ID_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = {N_REQ{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/arb_prio_enc8.sv
// arb_prio_enc8
// Combinational 8-input priority encoder.
// Ports:
//   vec        input  8  candidate vector
//   msb_first  input  1  1 = highest set bit wins, 0 = lowest set bit wins
//   index      output 3  winning bit position (0 when vec is empty)
//   any        output 1  vec has at least one bit set
module arb_prio_enc8
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] vec,
  input  logic             msb_first,
  output logic [ID_W-1:0]  index,
  output logic             any
);

  logic [ID_W-1:0] lsb_idx_s;
  logic [ID_W-1:0] msb_idx_s;

  // Lowest set bit: used on the rotated vector for round-robin search
  always_comb begin
    lsb_idx_s = 3'd0;
    casez (vec)
      8'b???????1: lsb_idx_s = 3'd0;
      8'b??????10: lsb_idx_s = 3'd1;
      8'b?????100: lsb_idx_s = 3'd2;
      8'b????1000: lsb_idx_s = 3'd3;
      8'b???10000: lsb_idx_s = 3'd4;
      8'b??100000: lsb_idx_s = 3'd5;
      8'b?1000000: lsb_idx_s = 3'd6;
      8'b10000000: lsb_idx_s = 3'd7;
      default:     lsb_idx_s = 3'd0;
    endcase
  end

  // Highest set bit: fixed-priority selection with bit 7 on top
  always_comb begin
    msb_idx_s = 3'd0;
    casez (vec)
      8'b1???????: msb_idx_s = 3'd7;
      8'b01??????: msb_idx_s = 3'd6;
      8'b001?????: msb_idx_s = 3'd5;
      8'b0001????: msb_idx_s = 3'd4;
      8'b00001???: msb_idx_s = 3'd3;
      8'b000001??: msb_idx_s = 3'd2;
      8'b0000001?: msb_idx_s = 3'd1;
      8'b00000001: msb_idx_s = 3'd0;
      default:     msb_idx_s = 3'd0;
    endcase
  end

  // Direction select and any-request flag
  always_comb begin
    any = |vec;
    if (msb_first) begin
      index = msb_idx_s;
    end else begin
      index = lsb_idx_s;
    end
  end

endmodule

// File: rtl/rr_req_arbiter8.sv
// rr_req_arbiter8
// Shares one downstream resource between 8 requesters. A winner is picked in
// IDLE, holds the grant in GRANT until done, loss of its own request, or the
// MAX_HOLD limit, then the arbiter spends one cycle in IDLE and re-arbitrates.
// The requester count and index width are fixed by arb_pkg (8 / 3).
// Parameters:
//   RR_EN     1 = round-robin after the last owner, 0 = fixed priority (bit 7 top)
//   MAX_HOLD  maximum grant length in cycles, 0 = unlimited
// Ports:
//   clk        input  1  rising-edge clock
//   rst        input  1  synchronous active-high reset
//   req        input  8  level request per requester
//   done       input  1  owner release pulse, ignored outside GRANT
//   grant      output 8  registered one-hot grant
//   grant_id   output 3  registered owner index, qualify with grant_vld
//   grant_vld  output 1  registered, high while a grant is active
//   timeout    output 1  one-cycle pulse when MAX_HOLD alone revokes a grant
module rr_req_arbiter8
  import arb_pkg::*;
#(
  parameter int RR_EN    = 1,
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_id,
  output logic             grant_vld,
  output logic             timeout
);

  localparam int              HC_W      = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam bit              HOLD_EN   = (MAX_HOLD > 0);
  localparam logic [HC_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HC_W'(MAX_HOLD - 1) : {HC_W{1'b0}};

  arb_state_t       state_r;
  arb_state_t       state_nxt_s;
  logic [HC_W-1:0]  hold_cnt_r;
  logic [HC_W-1:0]  hold_cnt_nxt_s;
  logic [ID_W-1:0]  rr_ptr_r;
  logic [ID_W-1:0]  rr_ptr_nxt_s;
  logic [N_REQ-1:0] grant_r;
  logic [N_REQ-1:0] grant_nxt_s;
  logic [ID_W-1:0]  grant_id_r;
  logic [ID_W-1:0]  grant_id_nxt_s;
  logic             grant_vld_r;
  logic             grant_vld_nxt_s;
  logic             timeout_r;
  logic             timeout_nxt_s;

  logic [ID_W-1:0]  search_base_s;
  logic [N_REQ-1:0] enc_vec_s;
  logic             enc_msb_first_s;
  logic [ID_W-1:0]  enc_idx_s;
  logic             enc_any_s;
  logic [ID_W-1:0]  winner_s;
  logic             owner_req_s;
  logic             hold_hit_s;
  logic             release_s;
  logic             timeout_only_s;

  // Encoder input: rotated so the search starts one past the last owner
  always_comb begin
    search_base_s   = rr_ptr_r + 3'd1;
    enc_vec_s       = req;
    enc_msb_first_s = 1'b1;
    if (RR_EN != 0) begin
      enc_vec_s       = rotate_right(req, search_base_s);
      enc_msb_first_s = 1'b0;
    end else begin
      enc_vec_s       = req;
      enc_msb_first_s = 1'b1;
    end
  end

  arb_prio_enc8 u_enc (
    .vec       (enc_vec_s),
    .msb_first (enc_msb_first_s),
    .index     (enc_idx_s),
    .any       (enc_any_s)
  );

  // Undo the rotation; the 3-bit add wraps 7 -> 0 on its own
  always_comb begin
    winner_s = enc_idx_s;
    if (RR_EN != 0) begin
      winner_s = enc_idx_s + search_base_s;
    end else begin
      winner_s = enc_idx_s;
    end
  end

  // Release conditions; timeout is flagged only when the hold limit is the sole cause
  always_comb begin
    owner_req_s    = req[grant_id_r];
    hold_hit_s     = HOLD_EN && (hold_cnt_r == HOLD_LAST);
    release_s      = done || !owner_req_s || hold_hit_s;
    timeout_only_s = hold_hit_s && !done && owner_req_s;
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (enc_any_s) begin
          state_nxt_s = GRANT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GRANT: begin
        if (release_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = GRANT;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Next values of the registered outputs, hold counter and rr pointer
  always_comb begin
    grant_nxt_s     = grant_r;
    grant_id_nxt_s  = grant_id_r;
    grant_vld_nxt_s = grant_vld_r;
    timeout_nxt_s   = 1'b0;
    hold_cnt_nxt_s  = hold_cnt_r;
    rr_ptr_nxt_s    = rr_ptr_r;
    case (state_r)
      IDLE: begin
        if (enc_any_s) begin
          grant_nxt_s     = onehot8(winner_s);
          grant_id_nxt_s  = winner_s;
          grant_vld_nxt_s = 1'b1;
          hold_cnt_nxt_s  = {HC_W{1'b0}};
        end else begin
          grant_nxt_s     = {N_REQ{1'b0}};
          grant_vld_nxt_s = 1'b0;
        end
      end
      GRANT: begin
        if (release_s) begin
          grant_nxt_s     = {N_REQ{1'b0}};
          grant_vld_nxt_s = 1'b0;
          rr_ptr_nxt_s    = grant_id_r;
          timeout_nxt_s   = timeout_only_s;
          hold_cnt_nxt_s  = {HC_W{1'b0}};
        end else if (hold_cnt_r != {HC_W{1'b1}}) begin
          hold_cnt_nxt_s  = hold_cnt_r + HC_W'(1'b1);
        end else begin
          hold_cnt_nxt_s  = hold_cnt_r;
        end
      end
      default: begin
        grant_nxt_s     = {N_REQ{1'b0}};
        grant_vld_nxt_s = 1'b0;
        hold_cnt_nxt_s  = {HC_W{1'b0}};
      end
    endcase
  end

  // State and output registers; rr_ptr resets to 7 so requester 0 is searched first
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      hold_cnt_r  <= {HC_W{1'b0}};
      rr_ptr_r    <= 3'd7;
      grant_r     <= {N_REQ{1'b0}};
      grant_id_r  <= 3'd0;
      grant_vld_r <= 1'b0;
      timeout_r   <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      hold_cnt_r  <= hold_cnt_nxt_s;
      rr_ptr_r    <= rr_ptr_nxt_s;
      grant_r     <= grant_nxt_s;
      grant_id_r  <= grant_id_nxt_s;
      grant_vld_r <= grant_vld_nxt_s;
      timeout_r   <= timeout_nxt_s;
    end
  end

  assign grant     = grant_r;
  assign grant_id  = grant_id_r;
  assign grant_vld = grant_vld_r;
  assign timeout   = timeout_r;

endmodule

// File: tb/tb_rr_req_arbiter8.sv
// tb_rr_req_arbiter8
// Three arbiter instances share one clock:
//   dut 0: round-robin, MAX_HOLD=16
//   dut 1: fixed priority, MAX_HOLD=16
//   dut 2: round-robin, MAX_HOLD=4
// Each step drives one instance on the falling edge, queues the outputs it
// should show after the next rising edge, and compares them 1 time unit later.
module tb_rr_req_arbiter8;

  typedef struct {
    int       dut;
    bit       rst;
    bit [7:0] req;
    bit       done;
    bit       vld;
    bit [2:0] id;
    bit       to;
    int       tag;
  } vec_t;

  typedef struct {
    int       dut;
    bit       vld;
    bit [2:0] id;
    bit       to;
    int       tag;
  } exp_t;

  logic       clk;
  logic [2:0] rst_v;
  logic [2:0] done_v;
  logic [7:0] req_v [3];
  wire  [7:0] grant_v [3];
  wire  [2:0] gid_v [3];
  wire  [2:0] vld_v;
  wire  [2:0] to_v;

  vec_t tbl[$];
  exp_t exp_q[$];
  int   checks;
  int   failures;

  rr_req_arbiter8 #(.RR_EN(1), .MAX_HOLD(16)) dut_rr (
    .clk(clk), .rst(rst_v[0]), .req(req_v[0]), .done(done_v[0]),
    .grant(grant_v[0]), .grant_id(gid_v[0]), .grant_vld(vld_v[0]), .timeout(to_v[0])
  );

  rr_req_arbiter8 #(.RR_EN(0), .MAX_HOLD(16)) dut_fp (
    .clk(clk), .rst(rst_v[1]), .req(req_v[1]), .done(done_v[1]),
    .grant(grant_v[1]), .grant_id(gid_v[1]), .grant_vld(vld_v[1]), .timeout(to_v[1])
  );

  rr_req_arbiter8 #(.RR_EN(1), .MAX_HOLD(4)) dut_to (
    .clk(clk), .rst(rst_v[2]), .req(req_v[2]), .done(done_v[2]),
    .grant(grant_v[2]), .grant_id(gid_v[2]), .grant_vld(vld_v[2]), .timeout(to_v[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input int dut, input bit rst, input bit [7:0] req,
                              input bit done, input bit vld, input bit [2:0] id,
                              input bit to);
    vec_t v;
    v.dut  = dut;
    v.rst  = rst;
    v.req  = req;
    v.done = done;
    v.vld  = vld;
    v.id   = id;
    v.to   = to;
    v.tag  = 0;
    return v;
  endfunction

  function automatic void add(input vec_t v);
    vec_t t;
    t     = v;
    t.tag = 100 * (v.dut + 1) + tbl.size();
    tbl.push_back(t);
  endfunction

  task automatic check(input string name, input int tag, input logic [7:0] act,
                       input logic [7:0] req_val);
    checks++;
    if (act !== req_val) begin
      failures++;
      $display("FAIL %s tag=%0d actual=%0h required=%0h", name, tag, act, req_val);
    end
  endtask

  task automatic compare_out();
    exp_t       e;
    logic [7:0] eg;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty actual=0 required=1");
    end else begin
      e  = exp_q.pop_front();
      eg = e.vld ? (8'h01 << e.id) : 8'h00;
      check("grant",     e.tag, grant_v[e.dut], eg);
      check("grant_vld", e.tag, {7'd0, vld_v[e.dut]}, {7'd0, e.vld});
      check("grant_id",  e.tag, {5'd0, gid_v[e.dut]}, {5'd0, e.id});
      check("timeout",   e.tag, {7'd0, to_v[e.dut]},  {7'd0, e.to});
    end
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    @(negedge clk);
    rst_v[v.dut]  = v.rst;
    req_v[v.dut]  = v.req;
    done_v[v.dut] = v.done;
    e.dut = v.dut;
    e.vld = v.vld;
    e.id  = v.id;
    e.to  = v.to;
    e.tag = v.tag;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    compare_out();
  endtask

  initial begin
    vec_t v;
    checks   = 0;
    failures = 0;
    rst_v    = 3'b111;
    done_v   = 3'b000;
    for (int i = 0; i < 3; i++) req_v[i] = 8'h00;

    // dut 0, round-robin: first grant, release causes, done in IDLE, sole requester
    add(mk(0, 1'b1, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0)); // reset state
    add(mk(0, 1'b0, 8'h81, 1'b0, 1'b1, 3'd0, 1'b0)); // rr_ptr=7 -> requester 0 first
    add(mk(0, 1'b0, 8'h81, 1'b0, 1'b1, 3'd0, 1'b0)); // held
    add(mk(0, 1'b0, 8'h81, 1'b1, 1'b0, 3'd0, 1'b0)); // done releases, id holds
    add(mk(0, 1'b0, 8'h81, 1'b0, 1'b1, 3'd7, 1'b0)); // search starts at 1 -> 7
    add(mk(0, 1'b0, 8'h01, 1'b0, 1'b0, 3'd7, 1'b0)); // owner req drop releases
    add(mk(0, 1'b0, 8'h01, 1'b0, 1'b1, 3'd0, 1'b0)); // wrap 7 -> 0
    add(mk(0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0));
    add(mk(0, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0)); // done in IDLE, no request
    add(mk(0, 1'b0, 8'h04, 1'b1, 1'b1, 3'd2, 1'b0)); // done in IDLE ignored
    add(mk(0, 1'b0, 8'h04, 1'b1, 1'b0, 3'd2, 1'b0)); // done releases
    add(mk(0, 1'b0, 8'h04, 1'b0, 1'b1, 3'd2, 1'b0)); // previous owner, sole requester
    add(mk(0, 1'b0, 8'h00, 1'b1, 1'b0, 3'd2, 1'b0)); // done + req drop: one release
    add(mk(0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd2, 1'b0));

    // dut 1, fixed priority
    add(mk(1, 1'b1, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0));
    add(mk(1, 1'b0, 8'h24, 1'b0, 1'b1, 3'd5, 1'b0)); // highest index wins
    add(mk(1, 1'b0, 8'h24, 1'b0, 1'b1, 3'd5, 1'b0));
    add(mk(1, 1'b0, 8'h04, 1'b0, 1'b0, 3'd5, 1'b0)); // 5 drops
    add(mk(1, 1'b0, 8'h04, 1'b0, 1'b1, 3'd2, 1'b0)); // 2 after one gap cycle
    add(mk(1, 1'b0, 8'h84, 1'b0, 1'b1, 3'd2, 1'b0)); // no preemption by 7
    add(mk(1, 1'b0, 8'h84, 1'b1, 1'b0, 3'd2, 1'b0));
    add(mk(1, 1'b0, 8'h84, 1'b0, 1'b1, 3'd7, 1'b0));
    add(mk(1, 1'b0, 8'h84, 1'b1, 1'b0, 3'd7, 1'b0));
    add(mk(1, 1'b0, 8'h84, 1'b0, 1'b1, 3'd7, 1'b0)); // no rotation: 7 again
    add(mk(1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd7, 1'b0));

    // dut 2, MAX_HOLD=4: timeout, and coincident done / req drop
    add(mk(2, 1'b1, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0));
    add(mk(2, 1'b0, 8'h08, 1'b0, 1'b1, 3'd3, 1'b0)); // grant cycle 1
    add(mk(2, 1'b0, 8'h08, 1'b0, 1'b1, 3'd3, 1'b0)); // 2
    add(mk(2, 1'b0, 8'h08, 1'b0, 1'b1, 3'd3, 1'b0)); // 3
    add(mk(2, 1'b0, 8'h08, 1'b0, 1'b1, 3'd3, 1'b0)); // 4
    add(mk(2, 1'b0, 8'h08, 1'b0, 1'b0, 3'd3, 1'b1)); // revoked, timeout pulse
    add(mk(2, 1'b0, 8'h08, 1'b0, 1'b1, 3'd3, 1'b0)); // re-granted, pulse gone
    add(mk(2, 1'b0, 8'h08, 1'b0, 1'b1, 3'd3, 1'b0));
    add(mk(2, 1'b0, 8'h08, 1'b0, 1'b1, 3'd3, 1'b0));
    add(mk(2, 1'b0, 8'h08, 1'b0, 1'b1, 3'd3, 1'b0));
    add(mk(2, 1'b0, 8'h08, 1'b1, 1'b0, 3'd3, 1'b0)); // done at hold limit: no timeout
    add(mk(2, 1'b0, 8'h08, 1'b0, 1'b1, 3'd3, 1'b0));
    add(mk(2, 1'b0, 8'h08, 1'b0, 1'b1, 3'd3, 1'b0));
    add(mk(2, 1'b0, 8'h08, 1'b0, 1'b1, 3'd3, 1'b0));
    add(mk(2, 1'b0, 8'h08, 1'b0, 1'b1, 3'd3, 1'b0));
    add(mk(2, 1'b0, 8'h00, 1'b0, 1'b0, 3'd3, 1'b0)); // req drop at hold limit: no timeout
    add(mk(2, 1'b0, 8'h28, 1'b0, 1'b1, 3'd5, 1'b0)); // search 4,5 -> 5
    add(mk(2, 1'b0, 8'h28, 1'b0, 1'b1, 3'd5, 1'b0));
    add(mk(2, 1'b0, 8'h28, 1'b0, 1'b1, 3'd5, 1'b0));
    add(mk(2, 1'b0, 8'h28, 1'b0, 1'b1, 3'd5, 1'b0));
    add(mk(2, 1'b0, 8'h28, 1'b0, 1'b0, 3'd5, 1'b1)); // timeout
    add(mk(2, 1'b0, 8'h28, 1'b0, 1'b1, 3'd3, 1'b0)); // search 6..3 -> 3

    repeat (2) @(posedge clk);
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Round-robin fairness on dut 0: all requesting, each owner pulses done
    v = mk(0, 1'b1, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0);
    v.tag = 400;
    apply(v);
    for (int k = 0; k < 9; k++) begin
      v = mk(0, 1'b0, 8'hFF, 1'b0, 1'b1, 3'(k % 8), 1'b0);
      v.tag = 401 + 2 * k;
      apply(v);
      v = mk(0, 1'b0, 8'hFF, 1'b1, 1'b0, 3'(k % 8), 1'b0);
      v.tag = 402 + 2 * k;
      apply(v);
    end

    // Mid-grant reset on dut 0: rr_ptr is 0 here, reset must return it to 7
    v = mk(0, 1'b0, 8'h40, 1'b0, 1'b1, 3'd6, 1'b0);
    v.tag = 500;
    apply(v);
    v = mk(0, 1'b0, 8'h40, 1'b0, 1'b1, 3'd6, 1'b0);
    v.tag = 501;
    apply(v);
    v = mk(0, 1'b1, 8'h41, 1'b0, 1'b0, 3'd0, 1'b0);
    v.tag = 502;
    apply(v);
    v = mk(0, 1'b0, 8'h41, 1'b0, 1'b1, 3'd0, 1'b0);
    v.tag = 503;
    apply(v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
